ready_list_ctrl: RTL and testbench
==================================

READY_LIST_CTRL -- requirements
Module: ready_list_ctrl

Interface
REQ-001 SHALL have parameter NSLOT, default 16, number of task slots; slot index is 4 bits.
REQ-002 SHALL have port aclk  input  1  the only clock; all state changes on rising edge.
REQ-003 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid and cmd_ready are both high at an edge.
REQ-006 SHALL have port cmd_op  input  2  command code: 00 NOP, 01 SET_READY, 10 CLR_READY, 11 SET_PRIO.
REQ-007 SHALL have port cmd_slot  input  4  target slot.
REQ-008 SHALL have port cmd_prio  input  6  priority for SET_PRIO; ignored otherwise.
REQ-009 SHALL have port addrread_in  input  8  current task pointer from the scheduler; only bits [3:0] are used.
REQ-010 SHALL have port highpriority_out  output  6  highest priority among ready slots.
REQ-011 SHALL have port ptr_hpritask_out  output  8  lowest-index ready slot at highpriority_out, zero-extended.
REQ-012 SHALL have port ptr_nexttask_out  output  8  next ready slot at highpriority_out after the current task, zero-extended.
REQ-013 SHALL have port ready_map_out  output  16  per-slot ready bits.

Function
REQ-014 SHALL hold per slot a ready bit and a 6-bit priority; a higher value means higher priority.
REQ-015 Slot 0 SHALL be the idle task: permanently ready at priority 0; CLR_READY and SET_PRIO on slot 0 are ignored, while still accepted and still triggering a scan.
REQ-016 An accepted command SHALL update the slot table at the accept edge.
REQ-017 NOP SHALL alter no table state but SHALL still trigger a scan.
REQ-018 FSM states SHALL be IDLE, SCAN_PRIO, SCAN_NEXT and UPDATE.
REQ-019 IDLE SHALL go to SCAN_PRIO on an accepted command or when addrread_in[3:0] differs from the latched current slot; otherwise it stays in IDLE.
REQ-020 On entering a scan, the FSM SHALL latch addrread_in[3:0] as the current slot.
REQ-021 SCAN_PRIO SHALL examine one slot per cycle, slots 0..15 in 16 cycles, tracking max priority and the first ready slot at that maximum (ties go to the lowest index).
REQ-022 SCAN_NEXT SHALL examine 16 slots, one per cycle, starting at (current+1) mod 16 and wrapping; the first ready slot whose priority equals the max is the next task.
REQ-023 If the current slot is the only ready slot at max priority, next SHALL equal the current slot.
REQ-024 UPDATE SHALL register all three result outputs in the same edge (atomic), then return to IDLE.
REQ-025 Outputs SHALL change exactly 33 edges after the accept/trigger edge; they are stable and hold old values throughout the scan.
REQ-026 cmd_ready SHALL be low in SCAN_PRIO, SCAN_NEXT and UPDATE; commands presented then are not accepted and must be held by the requester.
REQ-027 A change of addrread_in during a scan SHALL be ignored by that scan and SHALL trigger a new scan from IDLE if it differs from the latched value.
REQ-028 If a command and an addrread_in change coincide in IDLE, one scan SHALL cover both.
REQ-029 ready_map_out SHALL reflect the table immediately after the accept edge, not after UPDATE.
REQ-030 Scan counters SHALL be 4 bits with natural wrap 15->0.

Reset
REQ-031 While aresetn is low: state IDLE, slot 0 ready at priority 0, slots 1-15 not ready at priority 0, latched current slot 0.
REQ-032 While aresetn is low: highpriority_out=0, ptr_hpritask_out=0, ptr_nexttask_out=0, ready_map_out=16'h0001.
REQ-033 Reset asserted mid-scan SHALL abort the scan immediately; partial results are discarded.

Verification
REQ-034 Release reset with no commands -> outputs 0/0/0, ready_map 0x0001, cmd_ready=1.
REQ-035 SET_PRIO slot 3 to 5, then SET_READY slot 3 -> after 33 cycles: highpriority=5, hpritask=3, nexttask=3.
REQ-036 Slots 3, 7 and 12 ready at priority 5, addrread_in=7 -> hpritask=3, nexttask=12; then addrread_in=12 -> nexttask=3 (wrap-around).
REQ-037 CLR_READY slot 0 and SET_PRIO slot 0 to 9 -> ready_map bit 0 stays 1 and slot 0 priority stays 0; with all other slots cleared, outputs return to 0/0/0.
REQ-038 Command held during a scan -> not accepted until cmd_ready=1; aresetn pulsed low mid-scan -> REQ-032 values, FSM in IDLE.

Source files
------------

// File: rtl/ready_list_ctrl.sv
// ready_list_ctrl
// Ready-list bookkeeping for a small task scheduler. Holds a ready bit and a
// 6-bit priority per slot. After every accepted command, or whenever the
// scheduler's current-task pointer moves, it scans the table one slot per cycle.
// It then publishes three results together: the highest ready priority, the
// lowest-index slot at that priority, and the next slot at that priority after
// the current task.
//
// Ports
//   aclk              clock, all state changes on the rising edge
//   aresetn           asynchronous active-low reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op            00 NOP, 01 SET_READY, 10 CLR_READY, 11 SET_PRIO
//   cmd_slot          target slot
//   cmd_prio          new priority for SET_PRIO
//   addrread_in       current task pointer, bits [3:0] used
//   highpriority_out  highest priority among ready slots
//   ptr_hpritask_out  lowest-index ready slot at that priority
//   ptr_nexttask_out  next ready slot at that priority after the current one
//   ready_map_out     live per-slot ready bits
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting commands, watching addrread_in for a change
// SCAN_PRIO | slots 0..15 in turn: find max priority and first slot at it
// SCAN_NEXT | slots cur+1 .. cur (wrapping): first slot at max priority
// UPDATE    | publish all three results in one edge, back to IDLE

module ready_list_ctrl #(
  parameter int NSLOT = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_slot,
  input  logic [5:0]  cmd_prio,
  input  logic [7:0]  addrread_in,
  output logic [5:0]  highpriority_out,
  output logic [7:0]  ptr_hpritask_out,
  output logic [7:0]  ptr_nexttask_out,
  output logic [15:0] ready_map_out
);

  typedef enum logic [1:0] {IDLE, SCAN_PRIO, SCAN_NEXT, UPDATE} state_t;

  localparam logic [1:0] OP_SET_READY = 2'b01;
  localparam logic [1:0] OP_CLR_READY = 2'b10;
  localparam logic [1:0] OP_SET_PRIO  = 2'b11;

  state_t           state_q, state_d;
  logic [NSLOT-1:0] ready_q, ready_d;
  logic [5:0]       prio_q [NSLOT];
  logic [5:0]       prio_d [NSLOT];
  logic [3:0]       cur_q, cur_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       max_q, max_d;
  logic [3:0]       hpt_q, hpt_d;
  logic             found_q, found_d;
  logic [3:0]       nxt_q, nxt_d;
  logic             nfound_q, nfound_d;
  logic [5:0]       hp_out_q, hp_out_d;
  logic [3:0]       hpt_out_q, hpt_out_d;
  logic [3:0]       nxt_out_q, nxt_out_d;

  logic [3:0] scan_slot;
  logic       accept;
  logic       unused_addr_hi;

  assign unused_addr_hi = &addrread_in[7:4];

  // SCAN_NEXT walks from the slot after the current task; 4-bit add wraps.
  assign scan_slot = (state_q == SCAN_NEXT) ? (cur_q + cnt_q + 4'd1) : cnt_q;
  assign accept    = cmd_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    prio_d    = prio_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    hpt_d     = hpt_q;
    found_d   = found_q;
    nxt_d     = nxt_q;
    nfound_d  = nfound_q;
    hp_out_d  = hp_out_q;
    hpt_out_d = hpt_out_q;
    nxt_out_d = nxt_out_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Slot 0 is the idle task: it can never be cleared or re-prioritised.
          case (cmd_op)
            OP_SET_READY: ready_d[cmd_slot] = 1'b1;
            OP_CLR_READY: if (cmd_slot != 4'd0) ready_d[cmd_slot] = 1'b0;
            OP_SET_PRIO:  if (cmd_slot != 4'd0) prio_d[cmd_slot] = cmd_prio;
            default: ;
          endcase
        end
        if (accept || (addrread_in[3:0] != cur_q)) begin
          cur_d   = addrread_in[3:0];
          cnt_d   = 4'd0;
          max_d   = 6'd0;
          found_d = 1'b0;
          state_d = SCAN_PRIO;
        end
      end

      SCAN_PRIO: begin
        // Strict compare keeps the lowest index on ties.
        if (ready_q[scan_slot] && (!found_q || (prio_q[scan_slot] > max_q))) begin
          max_d   = prio_q[scan_slot];
          hpt_d   = scan_slot;
          found_d = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          nfound_d = 1'b0;
          state_d  = SCAN_NEXT;
        end
      end

      SCAN_NEXT: begin
        // The current slot is examined last, so it is the fallback when it is
        // the only ready slot at the max priority.
        if (!nfound_q && ready_q[scan_slot] && (prio_q[scan_slot] == max_q)) begin
          nxt_d    = scan_slot;
          nfound_d = 1'b1;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = UPDATE;
      end

      UPDATE: begin
        hp_out_d  = max_q;
        hpt_out_d = hpt_q;
        nxt_out_d = nxt_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      ready_q   <= {{(NSLOT-1){1'b0}}, 1'b1};
      for (int i = 0; i < NSLOT; i++) prio_q[i] <= 6'd0;
      cur_q     <= 4'd0;
      cnt_q     <= 4'd0;
      max_q     <= 6'd0;
      hpt_q     <= 4'd0;
      found_q   <= 1'b0;
      nxt_q     <= 4'd0;
      nfound_q  <= 1'b0;
      hp_out_q  <= 6'd0;
      hpt_out_q <= 4'd0;
      nxt_out_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      prio_q    <= prio_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      hpt_q     <= hpt_d;
      found_q   <= found_d;
      nxt_q     <= nxt_d;
      nfound_q  <= nfound_d;
      hp_out_q  <= hp_out_d;
      hpt_out_q <= hpt_out_d;
      nxt_out_q <= nxt_out_d;
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign highpriority_out = hp_out_q;
  assign ptr_hpritask_out = {4'd0, hpt_out_q};
  assign ptr_nexttask_out = {4'd0, nxt_out_q};
  assign ready_map_out    = ready_q;

endmodule

// File: tb/tb_ready_list_ctrl.sv
module tb_ready_list_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_slot = 4'd0;
  logic [5:0]  cmd_prio = 6'd0;
  logic [7:0]  addrread_in = 8'd0;
  logic [5:0]  highpriority_out;
  logic [7:0]  ptr_hpritask_out;
  logic [7:0]  ptr_nexttask_out;
  logic [15:0] ready_map_out;

  int checks = 0;
  int failures = 0;

  ready_list_ctrl #(.NSLOT(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .cmd_prio(cmd_prio),
    .addrread_in(addrread_in),
    .highpriority_out(highpriority_out),
    .ptr_hpritask_out(ptr_hpritask_out),
    .ptr_nexttask_out(ptr_nexttask_out),
    .ready_map_out(ready_map_out)
  );

  always #5 aclk = ~aclk;

  localparam logic [1:0] NOP = 2'b00, SETR = 2'b01, CLRR = 2'b10, SETP = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  slot;
    logic [5:0]  prio;
    logic [7:0]  addr;
    logic [5:0]  exp_hp;
    logic [7:0]  exp_hpt;
    logic [7:0]  exp_nxt;
    logic [15:0] exp_map;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] slot,
                        input logic [5:0] prio, input logic [7:0] addr);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    addrread_in = addr;
    cmd_op      = op;
    cmd_slot    = slot;
    cmd_prio    = prio;
    cmd_valid   = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] hp,
                            input logic [7:0] hpt, input logic [7:0] nxt);
    check({tag, "_hp"},  {26'd0, highpriority_out}, {26'd0, hp});
    check({tag, "_hpt"}, {24'd0, ptr_hpritask_out}, {24'd0, hpt});
    check({tag, "_nxt"}, {24'd0, ptr_nexttask_out}, {24'd0, nxt});
  endtask

  initial begin
    //        op    slot  prio  addr  hp  hpt  nxt  map
    vecs[0]  = '{SETP, 4'd3,  6'd5, 8'd0,  6'd0, 8'd0,  8'd0,  16'h0001};
    vecs[1]  = '{SETR, 4'd3,  6'd0, 8'd0,  6'd5, 8'd3,  8'd3,  16'h0009};
    vecs[2]  = '{SETP, 4'd7,  6'd5, 8'd0,  6'd5, 8'd3,  8'd3,  16'h0009};
    vecs[3]  = '{SETR, 4'd7,  6'd0, 8'd0,  6'd5, 8'd3,  8'd3,  16'h0089};
    vecs[4]  = '{SETP, 4'd12, 6'd5, 8'd0,  6'd5, 8'd3,  8'd3,  16'h0089};
    vecs[5]  = '{SETR, 4'd12, 6'd0, 8'd7,  6'd5, 8'd3,  8'd12, 16'h1089};
    vecs[6]  = '{NOP,  4'd0,  6'd0, 8'd12, 6'd5, 8'd3,  8'd3,  16'h1089};
    vecs[7]  = '{SETP, 4'd12, 6'd9, 8'd12, 6'd9, 8'd12, 8'd12, 16'h1089};
    vecs[8]  = '{CLRR, 4'd0,  6'd0, 8'd12, 6'd9, 8'd12, 8'd12, 16'h1089};
    vecs[9]  = '{SETP, 4'd0,  6'd9, 8'd0,  6'd9, 8'd12, 8'd12, 16'h1089};
    vecs[10] = '{CLRR, 4'd12, 6'd0, 8'd0,  6'd5, 8'd3,  8'd3,  16'h0089};
    vecs[11] = '{CLRR, 4'd3,  6'd0, 8'd3,  6'd5, 8'd7,  8'd7,  16'h0080 | 16'h0001};
    vecs[12] = '{SETP, 4'd7,  6'd0, 8'd3,  6'd0, 8'd0,  8'd7,  16'h0081};
    vecs[13] = '{CLRR, 4'd7,  6'd0, 8'd0,  6'd0, 8'd0,  8'd0,  16'h0001};

    // Reset values, both during and after reset.
    repeat (3) @(negedge aclk);
    check_outs("rst", 6'd0, 8'd0, 8'd0);
    check("rst_map", {16'd0, ready_map_out}, 32'h0001);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check_outs("rel", 6'd0, 8'd0, 8'd0);
    check("rel_map", {16'd0, ready_map_out}, 32'h0001);
    check("rel_ready", {31'd0, cmd_ready}, 32'd1);

    // Table: each command (with its pointer) runs one full scan.
    for (int i = 0; i < 14; i++) begin
      do_cmd(vecs[i].op, vecs[i].slot, vecs[i].prio, vecs[i].addr);
      check($sformatf("v%0d_map_now", i), {16'd0, ready_map_out}, {16'd0, vecs[i].exp_map});
      repeat (33) @(negedge aclk);
      check_outs($sformatf("v%0d", i), vecs[i].exp_hp, vecs[i].exp_hpt, vecs[i].exp_nxt);
      check($sformatf("v%0d_ready", i), {31'd0, cmd_ready}, 32'd1);
    end

    // Exact 33-edge latency; outputs hold and cmd_ready low during the scan.
    do_cmd(SETP, 4'd5, 6'd10, 8'd0);
    repeat (33) @(negedge aclk);
    do_cmd(SETR, 4'd5, 6'd0, 8'd0);
    check("lat_map_now", {16'd0, ready_map_out}, 32'h0021);
    begin
      int early = 0;
      int busy_bad = 0;
      for (int k = 1; k <= 33; k++) begin
        @(negedge aclk);
        if (k < 33) begin
          if (highpriority_out != 6'd0 || ptr_hpritask_out != 8'd0) early++;
          if (cmd_ready) busy_bad++;
        end
      end
      check("lat_early_change", early, 0);
      check("lat_ready_low", busy_bad, 0);
    end
    check_outs("lat", 6'd10, 8'd5, 8'd5);

    // Pointer move starts a scan; a command held meanwhile waits for cmd_ready.
    addrread_in = 8'd3;
    @(negedge aclk);
    cmd_op = SETR; cmd_slot = 4'd9; cmd_prio = 6'd0; cmd_valid = 1'b1;
    check("hold_ready_low", {31'd0, cmd_ready}, 32'd0);
    begin
      int n = 0;
      int early_acc = 0;
      while (!cmd_ready && n < 100) begin
        if (ready_map_out[9]) early_acc++;
        @(negedge aclk);
        n++;
      end
      check("hold_not_accepted", early_acc, 0);
      check("hold_wait_bound", {31'd0, cmd_ready}, 32'd1);
    end
    check_outs("ptr3", 6'd10, 8'd5, 8'd5);
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_op = NOP;
    check("hold_accepted_map", {16'd0, ready_map_out}, 32'h0221);

    // Reset in the middle of a scan discards it.
    repeat (33) @(negedge aclk);
    do_cmd(SETP, 4'd9, 6'd20, 8'd3);
    repeat (10) @(negedge aclk);
    aresetn = 1'b0;
    addrread_in = 8'd0;
    #1;
    check_outs("midrst", 6'd0, 8'd0, 8'd0);
    check("midrst_map", {16'd0, ready_map_out}, 32'h0001);
    check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (40) @(negedge aclk);
    check_outs("post_rst", 6'd0, 8'd0, 8'd0);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
